serial_cmd_driver: RTL and testbench
====================================

Name: serial_cmd_driver

Overview:
- Host-side master for the control unit's serial command interface.
- Accepts 8-bit instructions over a valid/ready handshake and serializes each one MSB-first onto the unit's data_in. Opcode is bits [7:6]; operand fields are bits [5:0].
- Sequences the mutually exclusive reset/shift/update/run strobes and captures the 8 bits the unit shifts out on data_out.
- Returns those captured bits to the host as a response word.

Parameters:
- RUN_CYCLES, 1: number of consecutive cycles ctl_run is held per command. Legal range 1..255.
- CNT_W, 8: width of the internal run counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low; 0 = reset.
- cmd_valid  input  1  host presents an instruction.
- cmd_data  input  8  instruction word: [7:6] opcode, [5:0] operands.
- cmd_ready  output  1  driver can accept an instruction this cycle.
- clr_req  input  1  request a control-unit reset pulse; sampled only in IDLE.
- ctl_reset  output  1  drives the unit's reset strobe.
- ctl_shift  output  1  drives the unit's shift strobe.
- ctl_update  output  1  drives the unit's update strobe.
- ctl_run  output  1  drives the unit's run strobe.
- ser_out  output  1  serial bit to the unit's data_in.
- ser_in  input  1  serial bit from the unit's data_out.
- rsp_valid  output  1  one-cycle pulse; rsp_data valid.
- rsp_data  output  8  bits shifted out of the unit during the last command.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Output registering:
  - All outputs are registered except cmd_ready and busy, which are decoded from state.
  - cmd_ready = (state == IDLE) && !clr_req.
- Reset (reset = 0, asynchronous):
  - state = IDLE; bit counter and run counter = 0.
  - ctl_* = 0, ser_out = 0, rsp_valid = 0, rsp_data = 8'h00, capture register = 0.
  - The remote unit's registers are not cleared by this reset; the host must issue clr_req to clear them.
- At most one ctl_* strobe is high in any cycle.
- IDLE:
  - clr_req = 1 -> CLEAR; clr_req has priority over cmd_valid.
  - Otherwise, cmd_valid && cmd_ready -> latch cmd_data and enter SHIFT.
  - On that accepting edge: ctl_shift <= 1, ser_out <= cmd_data[7], bit counter <= 0.
- CLEAR:
  - Exactly 1 cycle with ctl_reset = 1, then IDLE.
  - No response is produced.
- SHIFT:
  - 8 cycles, ctl_shift = 1.
  - In shift cycle k (k = 0..7), ser_out = cmd[7-k].
  - After k = 7 -> UPDATE.
- UPDATE:
  - 1 cycle, ctl_update = 1, ser_out = 0.
  - Then RUN with run counter = RUN_CYCLES-1.
- RUN:
  - ctl_run = 1 for exactly RUN_CYCLES cycles, then IDLE.
  - On entering IDLE, rsp_valid = 1 for one cycle and rsp_data = capture register.
- Capture:
  - The unit updates data_out on the same edge it shifts.
  - The driver therefore samples ser_in at the edges ending shift cycles 1..7 and the UPDATE cycle: 8 samples in total.
  - Each sample does cap <= {cap[6:0], ser_in}.
  - Result: rsp_data = the unit's shift register content before the command, MSB first.
- Latency:
  - rsp_valid rises 10+RUN_CYCLES cycles after the accepting edge.
  - The next command can be accepted in that same rsp_valid cycle.
  - Minimum command period is therefore 10+RUN_CYCLES cycles.
- rsp_data holds its value until the next rsp_valid.
- Changes on cmd_data, cmd_valid or clr_req outside IDLE are ignored.
- Reset asserted mid-command:
  - The in-flight command is abandoned and no rsp_valid is produced.
  - Strobes drop asynchronously.
- Run counter wrap: never wraps; RUN_CYCLES is limited to 2^CNT_W-1.

Test Plan:
- Serialization:
  - Stimulus: release reset, clr_req for 1 cycle, then command 8'h25 (init mem[2] = 5).
  - Required: ctl_reset high 1 cycle; then ser_out = 0,0,1,0,0,1,0,1 over 8 ctl_shift cycles; 1 ctl_update cycle; 1 ctl_run cycle; rsp_valid with rsp_data = 8'h00.
- Response capture:
  - Stimulus: command 8'hC7 directly after 8'h25, cmd_valid held high.
  - Required: accepted in the rsp_valid cycle of the first command; second rsp_data = 8'h25.
- Run length:
  - Stimulus: RUN_CYCLES = 3, command 8'h4B.
  - Required: ctl_run high exactly 3 consecutive cycles; rsp_valid 13 cycles after acceptance; strobes never overlap (checked every cycle).
- Clear priority:
  - Stimulus: clr_req and cmd_valid high together in IDLE.
  - Required: cmd_ready = 0; CLEAR cycle first; command accepted on the following IDLE cycle.
- Mid-shift reset:
  - Stimulus: reset asserted during shift cycle 4.
  - Required: all ctl_* and ser_out = 0 immediately; no rsp_valid; after release, cmd_ready = 1 and a fresh command completes normally.
- Backpressure:
  - Stimulus: cmd_valid asserted while busy.
  - Required: cmd_ready = 0 throughout; latched command bits unaffected by cmd_data changes.

Source files
------------

// File: rtl/serial_cmd_driver.sv
// Host-side master for a control unit's serial command port: serializes 8-bit
// instructions, sequences the reset/shift/update/run strobes and returns captured bits.
module serial_cmd_driver #(
    parameter int unsigned RUN_CYCLES = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    input  logic       clr_req,
    output logic       ctl_reset,
    output logic       ctl_shift,
    output logic       ctl_update,
    output logic       ctl_run,
    output logic       ser_out,
    input  logic       ser_in,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, UPDATE, RUN} state_t;

    state_t           state, state_nx;
    logic [6:0]       cmd_q, cmd_nx;
    logic [2:0]       bit_cnt, bit_nx;
    logic [CNT_W-1:0] run_cnt, run_cnt_nx;
    logic [7:0]       cap, cap_nx;
    logic             ctl_reset_nx, ctl_shift_nx, ctl_update_nx, ctl_run_nx;
    logic             ser_nx, rsp_valid_nx;
    logic [7:0]       rsp_data_nx;

    assign cmd_ready = (state == IDLE) && !clr_req;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx      = state;
        cmd_nx        = cmd_q;
        bit_nx        = bit_cnt;
        run_cnt_nx    = run_cnt;
        cap_nx        = cap;
        ctl_reset_nx  = 1'b0;
        ctl_shift_nx  = 1'b0;
        ctl_update_nx = 1'b0;
        ctl_run_nx    = 1'b0;
        ser_nx        = 1'b0;
        rsp_valid_nx  = 1'b0;
        rsp_data_nx   = rsp_data;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nx     = CLEAR;
                    ctl_reset_nx = 1'b1;
                end else if (cmd_valid && cmd_ready) begin
                    state_nx     = SHIFT;
                    cmd_nx       = cmd_data[6:0];
                    bit_nx       = '0;
                    ctl_shift_nx = 1'b1;
                    ser_nx       = cmd_data[7];
                end
            end
            CLEAR: state_nx = IDLE;
            SHIFT: begin
                // The unit's data_out lags its shift by one edge, so the first
                // shift cycle carries no useful sample.
                if (bit_cnt != 3'd0) begin
                    cap_nx = {cap[6:0], ser_in};
                end
                if (bit_cnt == 3'd7) begin
                    state_nx      = UPDATE;
                    ctl_update_nx = 1'b1;
                end else begin
                    bit_nx       = bit_cnt + 3'd1;
                    cmd_nx       = {cmd_q[5:0], 1'b0};
                    ctl_shift_nx = 1'b1;
                    ser_nx       = cmd_q[6];
                end
            end
            UPDATE: begin
                cap_nx     = {cap[6:0], ser_in};
                state_nx   = RUN;
                run_cnt_nx = CNT_W'(RUN_CYCLES - 1);
                ctl_run_nx = 1'b1;
            end
            RUN: begin
                if (run_cnt == '0) begin
                    state_nx     = IDLE;
                    rsp_valid_nx = 1'b1;
                    rsp_data_nx  = cap;
                end else begin
                    run_cnt_nx = run_cnt - 1'b1;
                    ctl_run_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cmd_q      <= '0;
            bit_cnt    <= '0;
            run_cnt    <= '0;
            cap        <= '0;
            ctl_reset  <= 1'b0;
            ctl_shift  <= 1'b0;
            ctl_update <= 1'b0;
            ctl_run    <= 1'b0;
            ser_out    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
        end else begin
            state      <= state_nx;
            cmd_q      <= cmd_nx;
            bit_cnt    <= bit_nx;
            run_cnt    <= run_cnt_nx;
            cap        <= cap_nx;
            ctl_reset  <= ctl_reset_nx;
            ctl_shift  <= ctl_shift_nx;
            ctl_update <= ctl_update_nx;
            ctl_run    <= ctl_run_nx;
            ser_out    <= ser_nx;
            rsp_valid  <= rsp_valid_nx;
            rsp_data   <= rsp_data_nx;
        end
    end

endmodule

// File: tb/tb_serial_cmd_driver.sv
// Directed bench for serial_cmd_driver: one instance with RUN_CYCLES=1 talking to a
// behavioural control-unit shift register, one with RUN_CYCLES=3 for run length.
module tb_serial_cmd_driver;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;

    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data  = '0;
    logic       clr_req   = 1'b0;
    logic       cmd_ready, ctl_reset, ctl_shift, ctl_update, ctl_run, ser_out, ser_in;
    logic       rsp_valid, busy;
    logic [7:0] rsp_data;

    logic       cmd_valid3 = 1'b0;
    logic [7:0] cmd_data3  = '0;
    logic       clr_req3   = 1'b0;
    logic       ser_in3    = 1'b0;
    logic       cmd_ready3, ctl_reset3, ctl_shift3, ctl_update3, ctl_run3, ser_out3;
    logic       rsp_valid3, busy3;
    logic [7:0] rsp_data3;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    serial_cmd_driver #(.RUN_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .clr_req(clr_req), .ctl_reset(ctl_reset),
        .ctl_shift(ctl_shift), .ctl_update(ctl_update), .ctl_run(ctl_run),
        .ser_out(ser_out), .ser_in(ser_in), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .busy(busy)
    );

    serial_cmd_driver #(.RUN_CYCLES(3), .CNT_W(8)) u_dut3 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid3), .cmd_data(cmd_data3),
        .cmd_ready(cmd_ready3), .clr_req(clr_req3), .ctl_reset(ctl_reset3),
        .ctl_shift(ctl_shift3), .ctl_update(ctl_update3), .ctl_run(ctl_run3),
        .ser_out(ser_out3), .ser_in(ser_in3), .rsp_valid(rsp_valid3),
        .rsp_data(rsp_data3), .busy(busy3)
    );

    // Control unit: data_out is a registered copy of the bit leaving the shift register.
    logic [7:0] unit_sr   = 8'hA5;
    logic       unit_dout = 1'b0;
    always @(posedge clk) begin
        if (ctl_reset) begin
            unit_sr   <= '0;
            unit_dout <= 1'b0;
        end else if (ctl_shift) begin
            unit_dout <= unit_sr[7];
            unit_sr   <= {unit_sr[6:0], ser_out};
        end
    end
    assign ser_in = unit_dout;

    logic [4:0] vec1, vec3;
    assign vec1 = {ctl_reset, ctl_shift, ctl_update, ctl_run, ser_out};
    assign vec3 = {ctl_reset3, ctl_shift3, ctl_update3, ctl_run3, ser_out3};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Expected {reset,shift,update,run,ser_out} in cycle n after acceptance (accept cycle = 0).
    function automatic logic [4:0] exp_vec(input int unsigned n, input logic [7:0] c,
                                           input int unsigned rc);
        logic [4:0] v;
        v = '0;
        if (n >= 1 && n <= 8)           v = {1'b0, 1'b1, 1'b0, 1'b0, c[3'(8 - n)]};
        else if (n == 9)                v = 5'b00100;
        else if (n >= 10 && n <= 9 + rc) v = 5'b00010;
        return v;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            cmd_valid3 = v;
            cmd_data3  = d;
        end else begin
            cmd_valid = v;
            cmd_data  = d;
        end
    endtask

    task automatic do_cmd(input bit sel, input logic [7:0] c, input logic [7:0] exp_rsp,
                          input int unsigned rc, input bit keep, input logic [7:0] nxt);
        int unsigned w;
        w = 0;
        drive(sel, 1'b1, c);
        #1;
        while (!(sel ? cmd_ready3 : cmd_ready) && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", 32'(sel ? cmd_ready3 : cmd_ready), 32'd1);
        for (int unsigned n = 1; n <= 10 + rc; n++) begin
            @(negedge clk);
            if (n < 10 + rc) begin
                check("strobes", 32'(sel ? vec3 : vec1), 32'(exp_vec(n, c, rc)));
                check("ready_busy", 32'(sel ? {cmd_ready3, busy3} : {cmd_ready, busy}), 32'd1);
                check("no_early_rsp", 32'(sel ? rsp_valid3 : rsp_valid), 32'd0);
            end else begin
                check("rsp_valid", 32'(sel ? rsp_valid3 : rsp_valid), 32'd1);
                check("rsp_data", 32'(sel ? rsp_data3 : rsp_data), 32'(exp_rsp));
                check("idle_strobes", 32'(sel ? vec3 : vec1), 32'd0);
                check("idle_busy", 32'(sel ? busy3 : busy), 32'd0);
            end
            if (n == 1) drive(sel, 1'b1, ~c);
            if (n == 9 + rc) drive(sel, keep, keep ? nxt : ~c);
        end
    endtask

    task automatic do_clear(input bit with_cmd, input logic [7:0] d);
        clr_req = 1'b1;
        if (with_cmd) drive(1'b0, 1'b1, d);
        #1;
        check("clr_ready_low", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("clr_strobe", 32'(vec1), 32'h10);
        check("clr_busy", 32'(busy), 32'd1);
        clr_req = 1'b0;
        @(negedge clk);
        check("clr_done", 32'(vec1), 32'd0);
        check("clr_no_rsp", 32'(rsp_valid), 32'd0);
        check("clr_ready", 32'(cmd_ready), 32'd1);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("onehot1", 32'($onehot0(vec1[4:1])), 32'd1);
            check("onehot3", 32'($onehot0(vec3[4:1])), 32'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_strobes", 32'(vec1), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_data}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd1);

        // Clear the unit, then back-to-back commands with cmd_valid held high.
        do_clear(1'b0, 8'h00);
        do_cmd(1'b0, 8'h25, 8'h00, 1, 1'b1, 8'hC7);
        check("b2b_rsp_cycle", 32'(rsp_valid), 32'd1);
        do_cmd(1'b0, 8'hC7, 8'h25, 1, 1'b0, 8'h00);

        // Clear wins over a simultaneous command, which follows one cycle later.
        do_clear(1'b1, 8'h3A);
        do_cmd(1'b0, 8'h3A, 8'h00, 1, 1'b0, 8'h00);

        // Reset during shift cycle 4: unit saw four shifts of 1,0,0,1 into 8'h3A -> 8'hA9.
        drive(1'b0, 1'b1, 8'h96);
        #1;
        check("mid_accept", 32'(cmd_ready), 32'd1);
        repeat (5) @(negedge clk);
        check("mid_shift4", 32'(vec1), 32'h08);
        reset = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        #1;
        check("mid_strobes", 32'(vec1), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("mid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        do_cmd(1'b0, 8'h5E, 8'hA9, 1, 1'b0, 8'h00);
        do_cmd(1'b0, 8'h81, 8'h5E, 1, 1'b0, 8'h00);
        @(negedge clk);
        check("rsp_pulse_end", 32'(rsp_valid), 32'd0);
        check("rsp_hold", 32'(rsp_data), 32'h5E);

        // RUN_CYCLES=3 instance: run held 3 cycles, response in cycle 13.
        do_cmd(1'b1, 8'h4B, 8'h00, 3, 1'b0, 8'h00);
        @(negedge clk);
        check("rc3_pulse_end", 32'(rsp_valid3), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
